// File: rtl/clk_div_fsk.sv
// ---------------------------------------------------------------------------
// clk_div_fsk
//
// Run-time programmable clock divider for the FSK transmit path. Produces a
// near-50% duty divided clock whose period is one of two programmed divisors,
// chosen per period by the symbol bit `sel`. Divisor and symbol are captured
// only at a period boundary (the load point), so out_clk never glitches when
// the tone changes.
//
// Parameters:
//   CNT_W    width of the divisors and of the period counter
//   DIV_MIN  smallest legal divisor; smaller programmed values are clamped up
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   en        run enable, sampled on every clk edge
//   sel       FSK symbol (0 -> div0, 1 -> div1), sampled at each load point
//   div0      period of tone 0 in clk cycles
//   div1      period of tone 1 in clk cycles
//   out_clk   registered divided clock
//   per_strb  one-cycle pulse registered together with each out_clk rise
//   cur_sel   symbol whose divisor is currently in effect
//
// Handshake: there is no valid/ready pair; en is a level-sensitive run
// enable. en=1 at an edge advances the divider, en=0 at an edge stops it
// abruptly and returns it to IDLE.
// ---------------------------------------------------------------------------
module clk_div_fsk #(
    parameter int CNT_W   = 16,
    parameter int DIV_MIN = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sel,
    input  logic [CNT_W-1:0] div0,
    input  logic [CNT_W-1:0] div1,
    output logic             out_clk,
    output logic             per_strb,
    output logic             cur_sel
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DMIN = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] d_act, d_act_nxt;
    logic             out_clk_nxt, per_strb_nxt, cur_sel_nxt;

    logic [CNT_W-1:0] d_sel;
    logic [CNT_W-1:0] d_new;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] last;

    // Divisor that would be loaded at this edge, clamped to the legal minimum.
    assign d_sel = sel ? div1 : div0;
    assign d_new = (d_sel < DMIN) ? DMIN : d_sel;

    // High phase is ceil(D/2) so odd divisors put the extra cycle high.
    // Written as D - D/2 so it cannot overflow at the maximum divisor.
    assign half = d_act - (d_act >> 1);
    // d_act >= DIV_MIN >= 2 always, so this never underflows.
    assign last = d_act - ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            d_act    <= DMIN;
            out_clk  <= 1'b0;
            per_strb <= 1'b0;
            cur_sel  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            d_act    <= d_act_nxt;
            out_clk  <= out_clk_nxt;
            per_strb <= per_strb_nxt;
            cur_sel  <= cur_sel_nxt;
        end
    end

    always_comb begin
        // Default: return everything to its reset value (IDLE with en=0, or
        // the abrupt stop from RUN when en drops).
        state_nxt    = IDLE;
        cnt_nxt      = '0;
        d_act_nxt    = DMIN;
        out_clk_nxt  = 1'b0;
        per_strb_nxt = 1'b0;
        cur_sel_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (en) begin
                    // Initial load point; out_clk rises on the following edge.
                    state_nxt   = RUN;
                    d_act_nxt   = d_new;
                    cur_sel_nxt = sel;
                end
            end
            RUN: begin
                if (en) begin
                    state_nxt   = RUN;
                    d_act_nxt   = d_act;
                    cur_sel_nxt = cur_sel;
                    out_clk_nxt = out_clk;

                    if (cnt == '0) begin
                        out_clk_nxt  = 1'b1;
                        per_strb_nxt = 1'b1;
                    end
                    // half >= 1, so this never collides with the cnt==0 rise.
                    if (cnt == half) begin
                        out_clk_nxt = 1'b0;
                    end

                    // Load point: the only place a new tone is accepted.
                    // For D=2 this coincides with the falling edge above.
                    if (cnt == last) begin
                        cnt_nxt     = '0;
                        d_act_nxt   = d_new;
                        cur_sel_nxt = sel;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_div_fsk.sv
module tb_clk_div_fsk;

    logic        clk;
    logic        rst;
    logic        en;
    logic        sel;
    logic [15:0] div0;
    logic [15:0] div1;
    logic        out_clk;
    logic        per_strb;
    logic        cur_sel;

    int checks = 0;
    int errors = 0;

    clk_div_fsk #(.CNT_W(16), .DIV_MIN(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sel      (sel),
        .div0     (div0),
        .div1     (div1),
        .out_clk  (out_clk),
        .per_strb (per_strb),
        .cur_sel  (cur_sel)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges, program the divider and raise en.
    // The next step() is the IDLE->RUN edge; the one after that is the rise.
    task automatic restart(input logic [15:0] d0, input logic [15:0] d1, input logic s);
        en   = 1'b0;
        rst  = 1'b1;
        #3;
        rst  = 1'b0;
        div0 = d0;
        div1 = d1;
        sel  = s;
        en   = 1'b1;
    endtask

    // Starting from the sample just after an out_clk rise, count high cycles,
    // low cycles and strobes until the next rise. Bounded loops.
    task automatic measure(output int hi, output int lo, output int strb);
        hi = 0;
        lo = 0;
        strb = 0;
        while (out_clk === 1'b1 && hi < 70000) begin
            hi++;
            if (per_strb === 1'b1) strb++;
            step();
        end
        while (out_clk === 1'b0 && lo < 70000) begin
            lo++;
            if (per_strb === 1'b1) strb++;
            step();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        en = 1'b0; sel = 1'b0; div0 = 16'd32; div1 = 16'd32;
        rst = 1'b1;
        step(); step();
        checks++; if (out_clk !== 1'b0) begin errors++; $display("FAIL reset_out_clk: got %b want 0", out_clk); end
        checks++; if (per_strb !== 1'b0) begin errors++; $display("FAIL reset_per_strb: got %b want 0", per_strb); end
        checks++; if (cur_sel !== 1'b0) begin errors++; $display("FAIL reset_cur_sel: got %b want 0", cur_sel); end
        rst = 1'b0;
        step(); step(); step();
        checks++; if (out_clk !== 1'b0) begin errors++; $display("FAIL idle_hold_out_clk: got %b want 0", out_clk); end
    endtask

    task automatic test_div32();
        int hi, lo, sb;
        restart(16'd32, 16'd7, 1'b0);
        step();
        checks++; if (out_clk !== 1'b0) begin errors++; $display("FAIL div32_first_edge: got %b want 0", out_clk); end
        step();
        checks++; if (out_clk !== 1'b1 || per_strb !== 1'b1) begin errors++; $display("FAIL div32_rise: got out=%b strb=%b want 1 1", out_clk, per_strb); end
        checks++; if (cur_sel !== 1'b0) begin errors++; $display("FAIL div32_cur_sel: got %b want 0", cur_sel); end
        for (int p = 0; p < 2; p++) begin
            measure(hi, lo, sb);
            checks++; if (hi !== 16 || lo !== 16) begin errors++; $display("FAIL div32_period%0d: got hi=%0d lo=%0d want 16 16", p, hi, lo); end
            checks++; if (sb !== 1) begin errors++; $display("FAIL div32_strobes%0d: got %0d want 1", p, sb); end
        end
    endtask

    task automatic test_small_div();
        int hi, lo, sb;
        restart(16'd5, 16'd9, 1'b0);
        step(); step();
        measure(hi, lo, sb);
        checks++; if (hi !== 3 || lo !== 2) begin errors++; $display("FAIL div5: got hi=%0d lo=%0d want 3 2", hi, lo); end
        // New div0 is written right after a rise: the current period keeps the
        // old divisor, the following one uses the new value.
        div0 = 16'd2;
        measure(hi, lo, sb);
        checks++; if (hi !== 3 || lo !== 2) begin errors++; $display("FAIL div5_hold: got hi=%0d lo=%0d want 3 2", hi, lo); end
        measure(hi, lo, sb);
        checks++; if (hi !== 1 || lo !== 1 || sb !== 1) begin errors++; $display("FAIL div2: got hi=%0d lo=%0d strb=%0d want 1 1 1", hi, lo, sb); end
        div0 = 16'd0;
        measure(hi, lo, sb);
        measure(hi, lo, sb);
        checks++; if (hi !== 1 || lo !== 1) begin errors++; $display("FAIL div0_clamp: got hi=%0d lo=%0d want 1 1", hi, lo); end
        div0 = 16'd1;
        measure(hi, lo, sb);
        measure(hi, lo, sb);
        checks++; if (hi !== 1 || lo !== 1) begin errors++; $display("FAIL div1_clamp: got hi=%0d lo=%0d want 1 1", hi, lo); end
    endtask

    task automatic test_fsk();
        int hi, lo, sb;
        restart(16'd8, 16'd12, 1'b0);
        step(); step();
        // Now at the rise sample (pre-edge cnt was 0). Raise sel in cycle 3.
        step(); step();
        sel = 1'b1;
        step(); step(); step(); step();
        checks++; if (cur_sel !== 1'b0) begin errors++; $display("FAIL fsk_cur_sel_mid: got %b want 0", cur_sel); end
        step();
        checks++; if (cur_sel !== 1'b1 || out_clk !== 1'b0) begin errors++; $display("FAIL fsk_load_edge: got sel=%b out=%b want 1 0", cur_sel, out_clk); end
        step();
        checks++; if (out_clk !== 1'b1 || per_strb !== 1'b1) begin errors++; $display("FAIL fsk_period8_end: got out=%b strb=%b want 1 1", out_clk, per_strb); end
        // div1 change after the load point must not affect the running period.
        div1 = 16'd4;
        measure(hi, lo, sb);
        checks++; if (hi !== 6 || lo !== 6) begin errors++; $display("FAIL fsk_period12: got hi=%0d lo=%0d want 6 6", hi, lo); end
        measure(hi, lo, sb);
        checks++; if (hi !== 2 || lo !== 2) begin errors++; $display("FAIL fsk_div1_reload: got hi=%0d lo=%0d want 2 2", hi, lo); end
        sel = 1'b0;
        measure(hi, lo, sb);
        checks++; if (cur_sel !== 1'b0 || hi !== 2) begin errors++; $display("FAIL fsk_back_to_0: got sel=%b hi=%0d want 0 2", cur_sel, hi); end
    endtask

    task automatic test_en_drop();
        restart(16'd3, 16'd8, 1'b1);
        step(); step();
        step();
        // Still in the high phase with cur_sel=1; stop abruptly.
        en = 1'b0;
        step();
        checks++; if (out_clk !== 1'b0 || per_strb !== 1'b0 || cur_sel !== 1'b0) begin errors++; $display("FAIL en_drop: got out=%b strb=%b sel=%b want 0 0 0", out_clk, per_strb, cur_sel); end
        step(); step();
        checks++; if (out_clk !== 1'b0) begin errors++; $display("FAIL en_drop_idle: got %b want 0", out_clk); end
        en = 1'b1;
        step();
        checks++; if (out_clk !== 1'b0) begin errors++; $display("FAIL reen_first_edge: got %b want 0", out_clk); end
        step();
        checks++; if (out_clk !== 1'b1 || per_strb !== 1'b1 || cur_sel !== 1'b1) begin errors++; $display("FAIL reen_rise: got out=%b strb=%b sel=%b want 1 1 1", out_clk, per_strb, cur_sel); end
    endtask

    task automatic test_async_rst();
        int hi, lo, sb;
        restart(16'd9, 16'd6, 1'b1);
        step(); step();
        // At edge+1 ns with out_clk=1, per_strb=1, cur_sel=1.
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_clk !== 1'b0 || per_strb !== 1'b0 || cur_sel !== 1'b0) begin errors++; $display("FAIL async_rst: got out=%b strb=%b sel=%b want 0 0 0", out_clk, per_strb, cur_sel); end
        #2;
        rst = 1'b0;
        step();
        checks++; if (out_clk !== 1'b0) begin errors++; $display("FAIL rst_restart_first: got %b want 0", out_clk); end
        step();
        checks++; if (out_clk !== 1'b1 || per_strb !== 1'b1) begin errors++; $display("FAIL rst_restart_rise: got out=%b strb=%b want 1 1", out_clk, per_strb); end
        measure(hi, lo, sb);
        checks++; if (hi !== 3 || lo !== 3) begin errors++; $display("FAIL rst_restart_period: got hi=%0d lo=%0d want 3 3", hi, lo); end
    endtask

    task automatic test_max_div();
        int hi, lo, sb;
        restart(16'hFFFF, 16'd4, 1'b0);
        step(); step();
        measure(hi, lo, sb);
        checks++; if (hi !== 32768 || lo !== 32767) begin errors++; $display("FAIL div_max: got hi=%0d lo=%0d want 32768 32767", hi, lo); end
        checks++; if (sb !== 1 || out_clk !== 1'b1 || per_strb !== 1'b1) begin errors++; $display("FAIL div_max_wrap: got strb=%0d out=%b want 1 1", sb, out_clk); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        rst = 1'b1; en = 1'b0; sel = 1'b0; div0 = '0; div1 = '0;
        test_reset();
        test_div32();
        test_small_div();
        test_fsk();
        test_en_drop();
        test_async_rst();
        test_max_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
